// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and a 6-digit decimal entry buffer.
// Rows are driven active-low one at a time; columns are read back on each scan tick.
module keypad_entry #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [23:0] digits,
  output logic [2:0]  digit_count,
  output logic [19:0] entered_value,
  output logic        entry_done
);

  localparam int TICK_DIV = ((CLK_HZ / SCAN_HZ) > 1) ? (CLK_HZ / SCAN_HZ) : 2;
  localparam int DIV_W    = $clog2(TICK_DIV);
  localparam int DEB_W    = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Position of the single low bit in an active-low one-hot vector.
  function automatic logic [1:0] f_low_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic f_single_low(input logic [3:0] v);
    logic one;
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one = 1'b1;
      default:                            one = 1'b0;
    endcase
    return one;
  endfunction

  function automatic logic [3:0] f_key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] f_rotate(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_scan_tick;
  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_sync;
  state_t           r_state;
  logic [3:0]       r_row;
  logic [3:0]       r_col_rec;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_key_valid;
  logic [3:0]       r_key_code;
  logic [23:0]      r_digits;
  logic [2:0]       r_digit_count;
  logic [19:0]      r_value;
  logic [19:0]      r_entered_value;
  logic             r_entry_done;

  logic [DEB_W-1:0] w_deb_next;
  logic             w_all_high;
  logic             w_single;
  logic             w_match;
  logic [19:0]      w_value_x10;

  assign w_deb_next  = r_deb_cnt + DEB_W'(1);
  assign w_all_high  = &r_col_sync;
  assign w_single    = f_single_low(r_col_sync);
  assign w_match     = (r_col_sync == r_col_rec);
  assign w_value_x10 = (r_value << 3) + (r_value << 1) + {16'd0, r_key_code};

  // Scan-rate divider producing a one-cycle tick on each wrap.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_scan_tick <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt   <= '0;
      r_scan_tick <= 1'b1;
    end else begin
      r_div_cnt   <= r_div_cnt + DIV_W'(1);
      r_scan_tick <= 1'b0;
    end
  end

  // Two-stage synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
    end else begin
      r_col_meta <= col;
      r_col_sync <= r_col_meta;
    end
  end

  // Scan/debounce state machine together with the entry buffer it updates.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_SCAN;
      r_row           <= 4'b1110;
      r_col_rec       <= 4'hF;
      r_deb_cnt       <= '0;
      r_key_valid     <= 1'b0;
      r_key_code      <= 4'h0;
      r_digits        <= 24'h0;
      r_digit_count   <= 3'd0;
      r_value         <= 20'd0;
      r_entered_value <= 20'd0;
      r_entry_done    <= 1'b0;
    end else begin
      r_key_valid  <= 1'b0;
      r_entry_done <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (r_scan_tick) begin
            // Multi-column presses are ghost-prone; treat them as no key.
            if (w_single) begin
              r_col_rec <= r_col_sync;
              r_deb_cnt <= DEB_W'(1);
              r_state   <= ST_DEBOUNCE;
            end else begin
              r_row <= f_rotate(r_row);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (r_scan_tick) begin
            if (w_match) begin
              r_deb_cnt <= w_deb_next;
              if (w_deb_next == DEB_LAST) begin
                r_state     <= ST_PRESSED;
                r_key_valid <= 1'b1;
                r_key_code  <= f_key_code(f_low_index(r_row), f_low_index(r_col_rec));
              end
            end else begin
              r_state <= ST_SCAN;
            end
          end
        end
        ST_PRESSED: begin
          r_deb_cnt <= '0;
          r_state   <= ST_RELEASE;
          case (r_key_code)
            4'hA, 4'hB, 4'hC, 4'hD: begin
            end
            4'hE: begin
              r_digits      <= 24'h0;
              r_digit_count <= 3'd0;
              r_value       <= 20'd0;
            end
            4'hF: begin
              r_entered_value <= r_value;
              r_entry_done    <= 1'b1;
              r_digits        <= 24'h0;
              r_digit_count   <= 3'd0;
              r_value         <= 20'd0;
            end
            default: begin
              if (r_digit_count < 3'd6) begin
                r_digits      <= {r_digits[19:0], r_key_code};
                r_digit_count <= r_digit_count + 3'd1;
                r_value       <= w_value_x10;
              end
            end
          endcase
        end
        ST_RELEASE: begin
          if (r_scan_tick) begin
            if (w_all_high) begin
              r_deb_cnt <= w_deb_next;
              if (w_deb_next == DEB_LAST) begin
                r_state <= ST_SCAN;
              end
            end else begin
              r_deb_cnt <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_SCAN;
        end
      endcase
    end
  end

  assign row           = r_row;
  assign key_valid     = r_key_valid;
  assign key_code      = r_key_code;
  assign digits        = r_digits;
  assign digit_count   = r_digit_count;
  assign entered_value = r_entered_value;
  assign entry_done    = r_entry_done;

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the multiplexed 6-digit 7-segment display path.
- The display path drives active-low digit selects and shows a 6-digit decimal value. This block drives active-low rows of a 4x4 matrix keypad and reads the columns.
- It debounces key presses and assembles a 6-digit decimal entry as BCD and binary.
- The resulting value (max 999999) feeds the display/counter logic as a user-entered number.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- SCAN_HZ, 1_000, rate of scan_tick; one row dwell per tick.
- DEBOUNCE_SCANS, 20, consecutive identical samples needed to accept a press or a release; must be >= 2.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- col  input  4  keypad columns, active-low, externally pulled up; asynchronous to clk_in.
- row  output  4  keypad row drive, active-low, exactly one bit low.
- key_valid  output  1  one-cycle pulse per accepted key press.
- key_code  output  4  code of the last accepted key; held until the next accepted key.
- digits  output  24  live entry buffer as 6 BCD nibbles; [3:0] is the most recently typed digit.
- digit_count  output  3  number of digits in the buffer, 0..6.
- entered_value  output  20  binary value latched when # is pressed.
- entry_done  output  1  one-cycle pulse when # is accepted.

Behaviour:
- Reset (async assert, sync release): row=4'b1110, key_valid=0, key_code=0, digits=0, digit_count=0, entered_value=0, entry_done=0, FSM=SCAN, all counters=0.
- Tick divider: counts 0..CLK_HZ/SCAN_HZ-1 and emits a one-cycle scan_tick on wrap.
- col passes through a 2-FF synchronizer. All column decisions use the synchronized value sampled on scan_tick.
- Key map, row index r=0..3 (active bit ~row), column index c=0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Codes: digits 0x0-0x9, A-D 0xA-0xD, * = 0xE, # = 0xF.
- SCAN:
  - On scan_tick with all columns high: rotate row 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - On scan_tick with exactly one column low: freeze row, record the column, set deb_cnt=1, go to DEBOUNCE.
  - On scan_tick with two or more columns low: ignore and keep rotating (ghosting rejected).
- DEBOUNCE:
  - On each scan_tick, if the sample matches the recorded column: deb_cnt++.
  - Otherwise return to SCAN; the row resumes rotating from the frozen row on the next tick.
  - When deb_cnt reaches DEBOUNCE_SCANS: go to PRESSED.
- PRESSED: lasts one cycle.
  - key_valid=1 and key_code updated in the same cycle.
  - Entry action (below) is applied; results are visible the next cycle.
  - Clear deb_cnt, go to RELEASE.
- RELEASE:
  - On scan_tick, all columns high: deb_cnt++. Any column low: deb_cnt=0.
  - At DEBOUNCE_SCANS: go to SCAN and resume rotation.
  - Holding a key produces exactly one key_valid; no auto-repeat.
- Entry actions:
  - Digit d with digit_count<6: digits={digits[19:0],d}, digit_count++, internal value=value*10+d (20-bit; max 999999 fits).
  - Digit d with digit_count==6: ignored, but key_valid still pulses.
  - 0xE (*): clears digits, digit_count and value.
  - 0xF (#): entered_value=value, entry_done=1 for that one cycle, then buffer cleared as for *. # on an empty buffer gives entered_value=0 with entry_done pulsed.
  - 0xA-0xD: key_valid pulses; buffer unchanged.
- Leading zeros are counted as digits: typing 0,0,5 gives digit_count=3, value=5.
- Reset mid-operation (any state) returns to SCAN with everything cleared. A key still held after reset is debounced and reported as a new press.

Test Plan:
- Use CLK_HZ=1000, SCAN_HZ=100, DEBOUNCE_SCANS=3, so one tick every 10 clocks.
- After reset, idle for 80 clocks -> row cycles 1110,1101,1011,0111,1110, changing every 10 clocks; key_valid never pulses.
- Hold key 5 (col[1] low while row==1101) for 100 clocks -> exactly one key_valid with key_code=5; digits=0x000005, digit_count=1.
- Press 1,2,3,4,5,6,7, then # -> 7 ignored with digit_count staying 6; on #, entered_value=123456 (0x1E240) with a one-cycle entry_done; then digits=0, digit_count=0.
- Key 9 bounces low/high on alternate ticks for 6 ticks, then stays low -> no key_valid during bouncing; exactly one key_valid (code 9) 3 ticks after it settles.
- Columns 0 and 1 low together on row 0 -> no key_valid; row keeps rotating.
- Type 4,2, press * then #; separately assert rst_n low while in DEBOUNCE -> * clears the buffer and # gives entered_value=0 with entry_done; the reset forces row=1110 and all outputs to 0 immediately.
